// File: rtl/keypad_pkg.sv
// Shared types, constants and key decode helpers for the 4x3 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam logic [3:0] KEY_STAR  = 4'd10;
  localparam logic [3:0] KEY_HASH  = 4'd11;
  localparam logic [3:0] ROWS_IDLE = 4'b1111;

  // Row r, column c -> key code; column index 3 is treated as column 0.
  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    logic [1:0] c;
    c = (col == 2'd3) ? 2'd0 : col;
    if (row == 2'd3) begin
      case (c)
        2'd0:    key_code = KEY_STAR;
        2'd1:    key_code = 4'd0;
        default: key_code = KEY_HASH;
      endcase
    end else begin
      key_code = ({2'b00, row} * 4'd3) + {2'b00, c} + 4'd1;
    end
  endfunction

  function automatic logic one_low(input logic [3:0] rows);
    case (rows)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: one_low = 1'b1;
      default:                            one_low = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] low_index(input logic [3:0] rows);
    case (rows)
      4'b1101: low_index = 2'd1;
      4'b1011: low_index = 2'd2;
      4'b0111: low_index = 2'd3;
      default: low_index = 2'd0;
    endcase
  endfunction

  function automatic logic [3:0] row_pattern(input logic [1:0] row);
    row_pattern = ~(4'b0001 << row);
  endfunction

  function automatic logic [2:0] col_drive(input logic [1:0] idx);
    case (idx)
      2'd1:    col_drive = 3'b101;
      2'd2:    col_drive = 3'b011;
      default: col_drive = 3'b110;
    endcase
  endfunction

  function automatic logic [1:0] next_col(input logic [1:0] idx);
    case (idx)
      2'd0:    next_col = 2'd1;
      2'd1:    next_col = 2'd2;
      default: next_col = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchronizer; resets to all ones to match idle pulled-up inputs.
module sync2 #(
  parameter int W = 1
) (
  input  logic         CLK,
  input  logic         RESET_N,
  input  logic [W-1:0] D,
  output logic [W-1:0] Q
);

  logic [W-1:0] meta;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      meta <= '1;
      Q    <= '1;
    end else begin
      meta <= D;
      Q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: column scan, press/release debounce, one pulse per press.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 4,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int CNT_W           = 8
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [3:0] ROW,
  output logic [2:0] COL,
  output logic [3:0] ITEM_CODE,
  output logic       KEY_PRESS,
  output logic       CLEAR,
  output logic       BUSY
);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [3:0]       rs;
  state_t           state_q, state_d;
  logic [1:0]       col_q, col_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       key_row_q, key_row_d;
  logic [1:0]       key_col_q, key_col_d;
  logic             fire_q, fire_d;
  logic [3:0]       code;

  sync2 #(.W(4)) u_row_sync (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .D       (ROW),
    .Q       (rs)
  );

  assign code = key_code(key_row_q, key_col_q);
  assign COL  = col_drive(col_q);
  assign BUSY = (state_q != SCAN);

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    dwell_d   = dwell_q;
    cnt_d     = cnt_q;
    key_row_d = key_row_q;
    key_col_d = key_col_q;
    fire_d    = 1'b0;
    case (state_q)
      SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (one_low(rs)) begin
            key_row_d = low_index(rs);
            key_col_d = (col_q == 2'd3) ? 2'd0 : col_q;
            cnt_d     = '0;
            state_d   = DEBOUNCE;
          end else begin
            // Idle or ghosting across several rows: move on to the next column.
            col_d = next_col(col_q);
          end
        end else if (dwell_q != CNT_MAX) begin
          dwell_d = dwell_q + CNT_ONE;
        end
      end
      DEBOUNCE: begin
        if (rs == row_pattern(key_row_q)) begin
          if (cnt_q >= DEB_LAST) begin
            state_d = HELD;
            fire_d  = 1'b1;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          state_d = SCAN;
          col_d   = next_col(col_q);
          dwell_d = '0;
        end
      end
      HELD: begin
        if (rs == ROWS_IDLE) begin
          cnt_d   = '0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (rs == ROWS_IDLE) begin
          if (cnt_q >= DEB_LAST) begin
            state_d = SCAN;
            col_d   = 2'd0;
            dwell_d = '0;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          cnt_d   = '0;
          state_d = HELD;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= SCAN;
      col_q     <= 2'd0;
      dwell_q   <= '0;
      cnt_q     <= '0;
      key_row_q <= 2'd0;
      key_col_q <= 2'd0;
      fire_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      dwell_q   <= dwell_d;
      cnt_q     <= cnt_d;
      key_row_q <= key_row_d;
      key_col_q <= key_col_d;
      fire_q    <= fire_d;
    end
  end

  // fire_q marks the first HELD cycle; pulses follow it by one edge.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ITEM_CODE <= 4'd0;
      KEY_PRESS <= 1'b0;
      CLEAR     <= 1'b0;
    end else begin
      KEY_PRESS <= fire_q && (code <= 4'd9);
      CLEAR     <= fire_q && (code == KEY_STAR);
      if (fire_q && (code <= 4'd9)) begin
        ITEM_CODE <= code;
      end
    end
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Upstream front end for the vending machine controller. It scans a 4-row x 3-column matrix keypad, debounces key press and release, and decodes the key.
- Digit keys produce the 4-bit ITEM_CODE plus a one-cycle KEY_PRESS pulse, which feed the controller's ITEM_CODE/KEY_PRESS inputs directly.
- '*' produces a one-cycle CLEAR pulse. '#' is ignored.
- Guarantees one pulse per physical press, regardless of hold time or bounce.

Parameters:
- SCAN_DIV, 4: clock cycles each column is driven before ROW is sampled (min 3).
- DEBOUNCE_CYCLES, 8: consecutive stable sampled cycles required for press and for release acceptance (min 2).
- CNT_W, 8: width of the dwell and debounce counters; must hold max(SCAN_DIV, DEBOUNCE_CYCLES).

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- ROW  input  4  keypad rows, active-low (pulled up); asynchronous to CLK.
- COL  output  3  column drive, active-low, one-hot-low; exactly one bit low at all times after reset.
- ITEM_CODE  output  4  last accepted digit 0-9; holds until the next digit is accepted.
- KEY_PRESS  output  1  one-cycle pulse when a digit is accepted; ITEM_CODE is valid in the same cycle.
- CLEAR  output  1  one-cycle pulse when '*' is accepted.
- BUSY  output  1  high in any state other than SCAN.

Behaviour:
- Reset (async assert, sync release) sets:
  - state=SCAN, column index 0, COL=3'b110
  - counters 0, sync flops 4'b1111
  - ITEM_CODE=0, KEY_PRESS=0, CLEAR=0, BUSY=0
- ROW passes through a 2-flop synchronizer. All decisions use the synchronized value rs.
- Key map, row r / column c:
  - r0: 1 2 3
  - r1: 4 5 6
  - r2: 7 8 9
  - r3: * 0 #
- SCAN state:
  - Drive the current column. The dwell counter counts 0..SCAN_DIV-1.
  - At dwell==SCAN_DIV-1, sample rs:
    - Exactly one bit low: latch row/col into key regs, clear debounce counter, go to DEBOUNCE. The column stays frozen.
    - rs all high, or 2+ bits low (ghost/multi-key): advance column 0->1->2->0, reset dwell.
- DEBOUNCE state:
  - Each cycle rs equals the latched pattern: increment the counter.
  - Any mismatch: go to SCAN, advance column, reset dwell. No output.
  - When the counter reaches DEBOUNCE_CYCLES-1 with a match, go to HELD. In that transition cycle, registered outputs assert on the next edge:
    - Digit: ITEM_CODE<=digit, KEY_PRESS<=1.
    - '*': CLEAR<=1, ITEM_CODE unchanged.
    - '#': no output.
- HELD state:
  - The column stays frozen.
  - When rs==4'b1111, clear the counter and go to RELEASE.
  - A second key in the same column does not re-trigger.
- RELEASE state:
  - Count consecutive cycles with rs==4'b1111.
  - Any low bit: go back to HELD (counter cleared).
  - At DEBOUNCE_CYCLES-1, go to SCAN with column 0 and dwell 0.
- Pulse rules:
  - KEY_PRESS and CLEAR are each high for exactly one cycle and never high together.
  - They are 0 in every cycle not immediately following a DEBOUNCE->HELD transition.
- Latency: KEY_PRESS rises exactly DEBOUNCE_CYCLES+1 edges after the SCAN->DEBOUNCE edge, given stable input.
- Reset mid-operation: immediate return to the reset values. Any pending pulse is dropped, and no pulse is generated after release.
- Counters saturate and never wrap. Column index 3 is illegal; decode it as 0.

Decomposition:
- Package keypad_pkg:
  - state encodings SCAN=2'd0, DEBOUNCE=2'd1, HELD=2'd2, RELEASE=2'd3
  - constants KEY_STAR=4'd10, KEY_HASH=4'd11, ROWS_IDLE=4'b1111
  - the row/col to code lookup function
- One sub-module: sync2, a generic 2-flop synchronizer (width parameter, async active-low reset to 1s), instantiated on ROW.

Test Plan (SCAN_DIV=4, DEBOUNCE_CYCLES=8):
- Reset release with ROW=4'hF -> COL rotates 110,101,011,110 every 4 cycles; KEY_PRESS never asserts over 100 cycles.
- Press '5' (ROW=4'b1101 whenever COL=3'b101) held 200 cycles, then released -> exactly one KEY_PRESS with ITEM_CODE=5. After release+8 cycles, BUSY=0 and COL=3'b110.
- Press '7' bouncing 3 cycles high/low for 20 cycles, then stable -> one KEY_PRESS with ITEM_CODE=7. No pulse during the bounce.
- Press '*' then '0' -> CLEAR pulse, ITEM_CODE unchanged (7); then KEY_PRESS with ITEM_CODE=0. KEY_PRESS and CLEAR never overlap.
- Press '#', or rows 0 and 1 low together -> no KEY_PRESS or CLEAR. Scanning continues for multi-key; '#' waits for release.
- RESET_N low for 1 cycle mid-DEBOUNCE of '9' -> outputs reset asynchronously, no KEY_PRESS. The key is re-detected only after a fresh scan and debounce.
